// File: rtl/mt9v034_i2c_responder.sv
// I2C responder for the MT9V034 register map: 8-bit register address, 16-bit MSB-first data.
// Define I2C_RESP_AUTOINC_EN to advance the register pointer after every written or read word.
module mt9v034_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR      = 7'h48,
  parameter int          REG_DEPTH     = 256,
  parameter logic [15:0] CHIP_ID       = 16'h1324,
  parameter int          GLITCH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic [7:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        busy
);

  localparam int CW = $clog2(GLITCH_CYCLES + 1);
  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
`ifdef I2C_RESP_AUTOINC_EN
  localparam logic [7:0] PTR_STEP = 8'd1;
`else
  localparam logic [7:0] PTR_STEP = 8'd0;
`endif

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG, ACK_REG, WR_MSB, ACK_WMSB, WR_LSB, ACK_WLSB,
    RD_MSB, MACK_MSB, RD_LSB, MACK_LSB, IGNORE
  } state_t;

  function automatic logic in_range(input logic [7:0] a);
    return (32'(a) < REG_DEPTH);
  endfunction

  // Bit 1 carries SCL, bit 0 carries SDA through the conditioning chain.
  logic [1:0]    s1_q, s1_d, s2_q, s2_d, filt_q, filt_d, prev_q, prev_d;
  logic [CW-1:0] fcnt_q [2];
  logic [CW-1:0] fcnt_d [2];

  state_t      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  wr_msb_q, wr_msb_d;
  logic [15:0] rd_word_q, rd_word_d;
  logic        rw_q, rw_d;
  logic        mack_q, mack_d;
  logic [7:0]  ptr_q, ptr_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic [7:0]  reg_wr_addr_q, reg_wr_addr_d;
  logic [15:0] reg_wr_data_q, reg_wr_data_d;
  logic [15:0] regs_q [REG_DEPTH];
  logic [15:0] regs_d [REG_DEPTH];

  logic        scl_f, sda_f, scl_p, sda_p;
  logic        scl_rise, scl_fall, start_c, stop_c;
  logic [15:0] rd_data;
  logic [15:0] wr_word;

  always_comb begin
    s1_d   = {scl_i, sda_i};
    s2_d   = s1_q;
    filt_d = filt_q;
    prev_d = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = '0;
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == CW'(GLITCH_CYCLES - 1)) filt_d[i] = s2_q[i];
        else                                      fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  assign scl_f    = filt_q[1];
  assign sda_f    = filt_q[0];
  assign scl_p    = prev_q[1];
  assign sda_p    = prev_q[0];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  assign rd_data = in_range(ptr_q) ? regs_q[ptr_q[AW-1:0]] : 16'h0000;
  assign wr_word = {wr_msb_q, shift_q};

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    wr_msb_d      = wr_msb_q;
    rd_word_d     = rd_word_q;
    rw_d          = rw_q;
    mack_d        = mack_q;
    ptr_d         = ptr_q;
    sda_oe_d      = sda_oe_q;
    busy_d        = busy_q;
    reg_wr_en_d   = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    regs_d        = regs_q;

    if (start_c) begin
      state_d   = DEV;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_oe_d  = 1'b0;
    end else if (stop_c) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      sda_oe_d = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        DEV, REG, WR_MSB, WR_LSB: begin
          shift_d   = {shift_q[6:0], sda_f};
          bit_cnt_d = bit_cnt_q + 4'd1;
          // Read data is frozen when the R/W bit is clocked in.
          if (state_q == DEV && bit_cnt_q == 4'd7) rd_word_d = rd_data;
        end
        RD_MSB, RD_LSB:     bit_cnt_d = bit_cnt_q + 4'd1;
        MACK_MSB, MACK_LSB: mack_d = sda_f;
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        DEV: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          if (shift_q[7:1] == DEV_ADDR) begin
            state_d  = ACK_DEV;
            sda_oe_d = 1'b1;
            rw_d     = shift_q[0];
          end else begin
            state_d  = IGNORE;
            sda_oe_d = 1'b0;
          end
        end
        ACK_DEV: begin
          if (rw_q) begin
            state_d  = RD_MSB;
            sda_oe_d = ~rd_word_q[15];
          end else begin
            state_d  = REG;
            sda_oe_d = 1'b0;
          end
        end
        REG: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          ptr_d     = shift_q;
          state_d   = ACK_REG;
          sda_oe_d  = 1'b1;
        end
        ACK_REG: begin
          state_d  = WR_MSB;
          sda_oe_d = 1'b0;
        end
        WR_MSB: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          wr_msb_d  = shift_q;
          state_d   = ACK_WMSB;
          sda_oe_d  = 1'b1;
        end
        ACK_WMSB: begin
          state_d  = WR_LSB;
          sda_oe_d = 1'b0;
        end
        WR_LSB: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = '0;
          state_d   = ACK_WLSB;
          sda_oe_d  = 1'b1;
        end
        ACK_WLSB: begin
          reg_wr_en_d   = 1'b1;
          reg_wr_addr_d = ptr_q;
          reg_wr_data_d = wr_word;
          // Register 0x00 holds the chip ID and is never overwritten.
          if (ptr_q != 8'h00 && in_range(ptr_q)) regs_d[ptr_q[AW-1:0]] = wr_word;
          ptr_d    = ptr_q + PTR_STEP;
          state_d  = WR_MSB;
          sda_oe_d = 1'b0;
        end
        RD_MSB: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            state_d   = MACK_MSB;
            sda_oe_d  = 1'b0;
          end else begin
            sda_oe_d = ~rd_word_q[{1'b1, ~bit_cnt_q[2:0]}];
          end
        end
        MACK_MSB: begin
          state_d  = RD_LSB;
          sda_oe_d = ~rd_word_q[7];
        end
        RD_LSB: begin
          if (bit_cnt_q == 4'd8) begin
            bit_cnt_d = '0;
            state_d   = MACK_LSB;
            sda_oe_d  = 1'b0;
            ptr_d     = ptr_q + PTR_STEP;
          end else begin
            sda_oe_d = ~rd_word_q[{1'b0, ~bit_cnt_q[2:0]}];
          end
        end
        MACK_LSB: begin
          if (!mack_q) begin
            rd_word_d = rd_data;
            state_d   = RD_MSB;
            sda_oe_d  = ~rd_data[15];
          end else begin
            state_d  = IGNORE;
            sda_oe_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= 2'b11;
      s2_q          <= 2'b11;
      filt_q        <= 2'b11;
      prev_q        <= 2'b11;
      fcnt_q[0]     <= '0;
      fcnt_q[1]     <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      ptr_q         <= '0;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      reg_wr_en_q   <= 1'b0;
      reg_wr_addr_q <= '0;
      reg_wr_data_q <= '0;
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= (i == 0) ? CHIP_ID : 16'h0000;
    end else begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      filt_q        <= filt_d;
      prev_q        <= prev_d;
      fcnt_q[0]     <= fcnt_d[0];
      fcnt_q[1]     <= fcnt_d[1];
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ptr_q         <= ptr_d;
      sda_oe_q      <= sda_oe_d;
      busy_q        <= busy_d;
      reg_wr_en_q   <= reg_wr_en_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      regs_q        <= regs_d;
    end
  end

  // Shift and snapshot registers are always written before being consumed.
  always_ff @(posedge clk) begin
    shift_q   <= shift_d;
    wr_msb_q  <= wr_msb_d;
    rd_word_q <= rd_word_d;
    rw_q      <= rw_d;
    mack_q    <= mack_d;
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign reg_wr_en   = reg_wr_en_q;
  assign reg_wr_addr = reg_wr_addr_q;
  assign reg_wr_data = reg_wr_data_q;

endmodule
